// File: rtl/rle_fifo_pkg.sv
// Shared constants for the RLE FIFO slice: default geometry, count width
// derivation and read-mode selectors.
package rle_fifo_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ADR_LEN = 4;

   // Read-port modes: registered read or first-word-fall-through.
   localparam int FIFO_MODE_REG  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Pointers and occupancy carry one extra wrap bit above the address.
   function automatic int cnt_w(input int adr_len);
      return adr_len + 1;
   endfunction

endpackage

// File: rtl/rle_fifo_mem.sv
// DEPTH x DATA_W storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module rle_fifo_mem
   import rle_fifo_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADR_LEN = DEF_ADR_LEN
)(
   input  logic               clk,
   input  logic               we,
   input  logic [ADR_LEN-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [ADR_LEN-1:0] raddr,
   output logic [DATA_W-1:0]  rdata
);

   localparam int DEPTH = 2**ADR_LEN;

   logic [DATA_W-1:0] mem_reg [DEPTH];

   // Store the incoming word at the write address on an accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   assign rdata = mem_reg[raddr];

endmodule

// File: rtl/rle_sync_fifo.sv
// Single-clock FIFO between the RLE token parser and the run expander.
// Wrap-bit pointers make all DEPTH entries usable; flags and count are
// decoded combinationally from the registered pointers.
module rle_sync_fifo
   import rle_fifo_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADR_LEN  = DEF_ADR_LEN,
   parameter int AF_LEVEL = 2**ADR_LEN - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = FIFO_MODE_REG
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              clr_err,
   input  logic              wr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADR_LEN:0]  count,
   output logic              overflow,
   output logic              underflow
);

   localparam int               CNT_W   = cnt_w(ADR_LEN);
   localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_LVL  = CNT_W'(AE_LEVEL);
   localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

   logic [CNT_W-1:0]  wptr_reg, wptr_next;
   logic [CNT_W-1:0]  rptr_reg, rptr_next;
   logic              overflow_reg, overflow_next;
   logic              underflow_reg, underflow_next;
   logic              we, re;
   logic [DATA_W-1:0] mem_rdata;

   assign fifo_empty   = (wptr_reg == rptr_reg);
   assign fifo_full    = (wptr_reg[ADR_LEN-1:0] == rptr_reg[ADR_LEN-1:0]) &&
                         (wptr_reg[ADR_LEN] != rptr_reg[ADR_LEN]);
   assign count        = wptr_reg - rptr_reg;
   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);

   // Flush swallows any request in the same cycle.
   assign we = wr & ~fifo_full & ~flush;
   assign re = rd & ~fifo_empty & ~flush;

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

   // Pointer advance / flush and sticky error update; a new error beats clr_err.
   always_comb begin
      wptr_next      = wptr_reg;
      rptr_next      = rptr_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (flush) begin
         wptr_next = '0;
         rptr_next = '0;
      end else begin
         if (we) wptr_next = wptr_reg + PTR_ONE;
         if (re) rptr_next = rptr_reg + PTR_ONE;
      end
      if (clr_err) begin
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end
      if (wr & fifo_full & ~flush)  overflow_next  = 1'b1;
      if (rd & fifo_empty & ~flush) underflow_next = 1'b1;
   end

   // Pointer and error-flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   rle_fifo_mem #(
      .DATA_W  (DATA_W),
      .ADR_LEN (ADR_LEN)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (wptr_reg[ADR_LEN-1:0]),
      .wdata (data_in),
      .raddr (rptr_reg[ADR_LEN-1:0]),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Head word is always presented; valid whenever something is stored.
         assign data_out = mem_rdata;
         assign rd_valid = ~fifo_empty;
      end else begin : g_reg
         logic [DATA_W-1:0] data_out_reg;
         logic              rd_valid_reg;

         // Capture the popped word; data holds between reads.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_out_reg <= '0;
               rd_valid_reg <= 1'b0;
            end else begin
               rd_valid_reg <= re;
               if (re) data_out_reg <= mem_rdata;
            end
         end

         assign data_out = data_out_reg;
         assign rd_valid = rd_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_rle_sync_fifo.sv
// Scoreboard bench for rle_sync_fifo: one registered-read instance and one
// FWFT instance (DEPTH=4, AF_LEVEL=3, AE_LEVEL=1) sharing clock and reset.
module tb_rle_sync_fifo;

   logic clk;
   logic rst_n;

   // registered-read instance
   logic       flush_r, clr_err_r, wr_r, rd_r;
   logic [7:0] data_in_r, data_out_r;
   logic       rd_valid_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
   logic [2:0] count_r;

   // FWFT instance
   logic       flush_f, clr_err_f, wr_f, rd_f;
   logic [7:0] data_in_f, data_out_f;
   logic       rd_valid_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
   logic [2:0] count_f;

   int n_total = 0;
   int n_bad   = 0;

   // registered-read model
   logic [7:0] exp_q[$];
   int         m_cnt;
   logic [7:0] m_last;
   logic       m_ovf, m_unf;

   // FWFT model
   logic [7:0] fq[$];
   int         fcnt;
   logic       f_ovf, f_unf;

   rle_sync_fifo #(
      .DATA_W(8), .ADR_LEN(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
   ) u_dut_reg (
      .clk(clk), .rst_n(rst_n), .flush(flush_r), .clr_err(clr_err_r),
      .wr(wr_r), .data_in(data_in_r), .rd(rd_r), .data_out(data_out_r),
      .rd_valid(rd_valid_r), .fifo_full(full_r), .fifo_empty(empty_r),
      .almost_full(af_r), .almost_empty(ae_r), .count(count_r),
      .overflow(ovf_r), .underflow(unf_r)
   );

   rle_sync_fifo #(
      .DATA_W(8), .ADR_LEN(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
   ) u_dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush_f), .clr_err(clr_err_f),
      .wr(wr_f), .data_in(data_in_f), .rd(rd_f), .data_out(data_out_f),
      .rd_valid(rd_valid_f), .fifo_full(full_f), .fifo_empty(empty_f),
      .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
      .overflow(ovf_f), .underflow(unf_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic models_reset();
      exp_q.delete();
      m_cnt  = 0;
      m_last = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      fq.delete();
      fcnt   = 0;
      f_ovf  = 1'b0;
      f_unf  = 1'b0;
   endtask

   // One clock on the registered-read instance; called at a negedge.
   task automatic step_r(input logic w, input logic [7:0] d, input logic r,
                         input logic fl, input logic ce);
      logic       acc_w, acc_r;
      logic [7:0] exp_d;
      acc_w = w && (m_cnt < 4) && !fl;
      acc_r = r && (m_cnt > 0) && !fl;
      if (w && (m_cnt == 4) && !fl) m_ovf = 1'b1;
      else if (ce)                  m_ovf = 1'b0;
      if (r && (m_cnt == 0) && !fl) m_unf = 1'b1;
      else if (ce)                  m_unf = 1'b0;
      wr_r = w; data_in_r = d; rd_r = r; flush_r = fl; clr_err_r = ce;
      @(posedge clk);
      @(negedge clk);
      wr_r = 1'b0; rd_r = 1'b0; flush_r = 1'b0; clr_err_r = 1'b0;
      if (fl) begin
         exp_q.delete();
         m_cnt = 0;
      end
      if (acc_r) begin
         exp_d  = exp_q.pop_front();
         m_last = exp_d;
         chk("r_rd_valid", 32'(rd_valid_r), 32'(1));
         chk("r_data", 32'(data_out_r), 32'(exp_d));
      end else begin
         chk("r_rd_valid_idle", 32'(rd_valid_r), 32'(0));
         if (!fl) chk("r_data_hold", 32'(data_out_r), 32'(m_last));
      end
      if (acc_w) exp_q.push_back(d);
      m_cnt = m_cnt + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
      chk("r_count", 32'(count_r), 32'(m_cnt));
      chk("r_full", 32'(full_r), 32'(m_cnt == 4));
      chk("r_empty", 32'(empty_r), 32'(m_cnt == 0));
      chk("r_afull", 32'(af_r), 32'(m_cnt >= 3));
      chk("r_aempty", 32'(ae_r), 32'(m_cnt <= 1));
      chk("r_overflow", 32'(ovf_r), 32'(m_ovf));
      chk("r_underflow", 32'(unf_r), 32'(m_unf));
      $display("txn reg  w=%0b d=%02h r=%0b fl=%0b ce=%0b -> cnt=%0d out=%02h vld=%0b",
               w, d, r, fl, ce, count_r, data_out_r, rd_valid_r);
   endtask

   // One clock on the FWFT instance; called at a negedge.
   task automatic step_f(input logic w, input logic [7:0] d, input logic r, input logic ce);
      logic acc_w, acc_r;
      logic [7:0] junk;
      acc_w = w && (fcnt < 4);
      acc_r = r && (fcnt > 0);
      if (w && (fcnt == 4)) f_ovf = 1'b1;
      else if (ce)          f_ovf = 1'b0;
      if (r && (fcnt == 0)) f_unf = 1'b1;
      else if (ce)          f_unf = 1'b0;
      wr_f = w; data_in_f = d; rd_f = r; clr_err_f = ce;
      @(posedge clk);
      @(negedge clk);
      wr_f = 1'b0; rd_f = 1'b0; clr_err_f = 1'b0;
      if (acc_r) junk = fq.pop_front();
      if (acc_w) fq.push_back(d);
      fcnt = fcnt + (acc_w ? 1 : 0) - (acc_r ? 1 : 0);
      chk("f_count", 32'(count_f), 32'(fcnt));
      chk("f_empty", 32'(empty_f), 32'(fcnt == 0));
      chk("f_rd_valid", 32'(rd_valid_f), 32'(fcnt != 0));
      if (fcnt > 0) chk("f_head", 32'(data_out_f), 32'(fq[0]));
      chk("f_overflow", 32'(ovf_f), 32'(f_ovf));
      chk("f_underflow", 32'(unf_f), 32'(f_unf));
      $display("txn fwft w=%0b d=%02h r=%0b ce=%0b -> cnt=%0d out=%02h vld=%0b",
               w, d, r, ce, count_f, data_out_f, rd_valid_f);
   endtask

   initial begin
      rst_n = 1'b0;
      flush_r = 1'b0; clr_err_r = 1'b0; wr_r = 1'b0; rd_r = 1'b0; data_in_r = 8'h00;
      flush_f = 1'b0; clr_err_f = 1'b0; wr_f = 1'b0; rd_f = 1'b0; data_in_f = 8'h00;
      models_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset then idle
      chk("rst_empty", 32'(empty_r), 32'(1));
      chk("rst_full", 32'(full_r), 32'(0));
      chk("rst_count", 32'(count_r), 32'(0));
      chk("rst_aempty", 32'(ae_r), 32'(1));
      chk("rst_afull", 32'(af_r), 32'(0));
      chk("rst_overflow", 32'(ovf_r), 32'(0));
      chk("rst_underflow", 32'(unf_r), 32'(0));
      chk("rst_data", 32'(data_out_r), 32'(0));
      chk("rst_rd_valid", 32'(rd_valid_r), 32'(0));
      chk("rst_f_empty", 32'(empty_f), 32'(1));
      chk("rst_f_rd_valid", 32'(rd_valid_f), 32'(0));
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // fill, overflow, clear, drain
      step_r(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      // full with wr and rd: only the read goes through
      step_r(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step_r(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // wrap: steady simultaneous traffic at count=2
      step_r(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step_r(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // empty with wr and rd: write taken, underflow; then set beats clr_err
      step_r(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // FWFT instance
      step_f(1'b1, 8'hA5, 1'b0, 1'b0);
      step_f(1'b0, 8'h00, 1'b1, 1'b0);
      step_f(1'b0, 8'h00, 1'b1, 1'b0);
      step_f(1'b0, 8'h00, 1'b0, 1'b1);
      step_f(1'b1, 8'hB1, 1'b0, 1'b0);
      step_f(1'b1, 8'hB2, 1'b0, 1'b0);
      step_f(1'b1, 8'hB3, 1'b1, 1'b0);
      step_f(1'b0, 8'h00, 1'b1, 1'b0);
      step_f(1'b0, 8'h00, 1'b1, 1'b0);

      // flush at count=3 with a write in the same cycle
      step_r(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0);
      step_r(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // asynchronous reset mid-burst, between clock edges
      step_r(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
      wr_r = 1'b1; data_in_r = 8'hE3; rd_r = 1'b1;
      @(posedge clk);
      #2;
      chk("pre_rst_rd_valid", 32'(rd_valid_r), 32'(1));
      chk("pre_rst_data", 32'(data_out_r), 32'(8'hE1));
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count_r), 32'(0));
      chk("arst_rd_valid", 32'(rd_valid_r), 32'(0));
      chk("arst_empty", 32'(empty_r), 32'(1));
      chk("arst_data", 32'(data_out_r), 32'(0));
      chk("arst_f_count", 32'(count_f), 32'(0));
      wr_r = 1'b0; rd_r = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      models_reset();
      step_r(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step_r(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
      step_r(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/rle_sync_fifo.md
Name: rle_sync_fifo

Overview:
- Single-clock, parametrised byte/word FIFO for the RLE decompression datapath.
- Sits between the RLE token parser and the run expander.
- Successor to the fixed 8-bit FIFO, with these additions:
  - generic data width and depth;
  - all DEPTH entries usable (extra-wrap-bit pointers);
  - occupancy count and programmable almost-full/almost-empty flags;
  - selectable first-word-fall-through (FWFT) or registered-read mode;
  - synchronous flush;
  - sticky overflow/underflow error flags.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADR_LEN, 4, address bits; DEPTH = 2**ADR_LEN entries (ADR_LEN >= 1).
- AF_LEVEL, 2**ADR_LEN - 2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- FWFT, 0, 0 = registered read (data one cycle after rd); 1 = head word shown on data_out whenever not empty.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents and pointers.
- clr_err  in  1  synchronous clear of sticky error flags.
- wr  in  1  write request.
- data_in  in  DATA_W  write data.
- rd  in  1  read request (FWFT=1: acknowledge/pop of head word).
- data_out  out  DATA_W  read data.
- rd_valid  out  1  FWFT=0: data_out holds a newly popped word this cycle; FWFT=1: equals ~fifo_empty.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADR_LEN+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers and flags:
  - wptr and rptr are ADR_LEN+1 bits; the MSB is the wrap bit and the low ADR_LEN bits address memory.
  - empty = (wptr == rptr).
  - full = low bits equal and MSBs differ.
  - count = wptr - rptr, modulo 2**(ADR_LEN+1).
- Accept rules:
  - we = wr & ~fifo_full.
  - re = rd & ~fifo_empty.
  - Both are evaluated on flags registered at the current edge. There is no write-through on full and no read-through on empty.
- Simultaneous wr and rd, neither full nor empty: both accepted, count unchanged.
- Full with wr and rd: only the read is accepted, count decrements, overflow sets.
- Empty with wr and rd: only the write is accepted, underflow sets.
- Wrap-around: pointers increment modulo 2**(ADR_LEN+1); the memory index wraps naturally at DEPTH.
- Memory:
  - Write on the clk edge when we: mem[wptr[ADR_LEN-1:0]] <= data_in.
  - Memory contents are not reset.
- FWFT=0:
  - On re, data_out <= mem[rptr] and rd_valid <= 1; otherwise rd_valid <= 0 and data_out holds.
  - Latency is one cycle from the rd edge to data.
- FWFT=1:
  - data_out = mem[rptr low bits], a combinational read.
  - rd pops the head, and the next word appears in the same cycle after the edge.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge.
- Flags: fifo_full, fifo_empty, almost_*, and count are combinational from the registered pointers. They update the cycle after the edge that moves a pointer.
- overflow/underflow:
  - Set on (wr & fifo_full) or (rd & fifo_empty) respectively.
  - Held until clr_err or reset. If set and clr_err coincide, set wins.
- flush:
  - wptr = rptr = 0 and rd_valid = 0 next edge. Error flags are unaffected.
  - wr/rd in the same cycle are ignored: no accept, no error set.
- Reset (rst_n low, asynchronous, any time including mid-burst):
  - wptr = rptr = 0.
  - data_out = 0, rd_valid = 0.
  - overflow = underflow = 0.
  - Hence fifo_empty = 1, fifo_full = 0, count = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0).
  - Release is sampled at the first clk edge after deassertion.

Decomposition:
- Shared package rle_fifo_pkg holds:
  - defaults (DATA_W = 8, ADR_LEN = 4);
  - the CNT_W = ADR_LEN+1 derivation;
  - the mode constants FIFO_MODE_REG = 0 and FIFO_MODE_FWFT = 1.
- One sub-module, rle_fifo_mem: a DEPTH x DATA_W array with a synchronous write port and an asynchronous read port.
- Pointer, flag, and error logic stay in rle_sync_fifo.

Test Plan:
All scenarios use DATA_W=8, ADR_LEN=2 (DEPTH=4), AF_LEVEL=3, AE_LEVEL=1.
- Reset then idle -> fifo_empty=1, count=0, almost_empty=1, overflow=0, data_out=0.
- Fill, FWFT=0:
  - Write 0x11,0x22,0x33,0x44 -> count=4, fifo_full=1, almost_full from count=3.
  - 5th write of 0x55 -> dropped, overflow=1.
  - 4 reads -> 0x11..0x44 each one cycle after rd with rd_valid=1, then fifo_empty=1.
- Wrap: 10 cycles of simultaneous wr/rd at count=2 (FWFT=0) -> count stays 2, data order preserved across pointer wrap, no error flags.
- FWFT=1:
  - Write 0xA5 into empty -> data_out=0xA5 and rd_valid=1 the next cycle.
  - rd -> fifo_empty=1.
  - rd on empty -> underflow=1; clr_err -> underflow=0.
- Mid-operation controls:
  - flush at count=3 with wr=1 -> count=0 next cycle, write not stored.
  - rst_n pulse mid-burst (between edges) -> count=0 and rd_valid=0 immediately, without a clock edge.
